// File: rtl/uart_cmd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl_pkg
// Shared definitions for the UART command sequencer: FSM state encoding,
// error cause codes, CMD byte field positions, the default frame start marker
// and small helper functions for the frame checksum and saturating counters.
// ----------------------------------------------------------------------------
package uart_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_DHI   = 3'd2,
      ST_DLO   = 3'd3,
      ST_CHK   = 3'd4,
      ST_WRITE = 3'd5
   } state_e;

   localparam logic [1:0] ERR_CHK     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_BADCMD  = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   localparam int CMD_WRITE_BIT = 7;
   localparam int CMD_ADDR_MSB  = 3;
   localparam int CMD_ADDR_LSB  = 0;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Frame checksum: XOR of the three payload bytes.
   function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
      return cmd ^ dhi ^ dlo;
   endfunction

   // 8-bit increment that sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_byte_timeout.sv
// ----------------------------------------------------------------------------
// byte_timeout
// Counts idle cycles while enabled. `expired` is high during the cycle in
// which the TIMEOUT_CYCLES-th consecutive idle cycle elapses.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clear         : restart the count (accepted byte or not in a timed state)
//   enable        : count only while high
//   expired       : timeout reached this cycle
// ----------------------------------------------------------------------------
module byte_timeout #(
   parameter int TIMEOUT_CYCLES = 270000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // The counter value equals the number of idle cycles already completed,
   // so the current cycle is the last allowed one when it reads LAST.
   assign expired = enable && (r_cnt == LAST);

   // Idle-cycle counter; holds at LAST until the owner leaves the timed state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= {CW{1'b0}};
      end else if (clear || !enable) begin
         r_cnt <= {CW{1'b0}};
      end else if (r_cnt != LAST) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses 5-byte frames (SYNC, CMD, DHI, DLO, CHK) from the debug UART byte
// stream and issues one handshaked register write per valid frame. Reports
// checksum, timeout, bad-command and overrun errors as one-cycle pulses.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   rx_data_i, rx_valid_i  : received byte and its one-cycle strobe
//   reg_we_o/addr_o/wdata_o: write request held until reg_ready_i
//   reg_ready_i            : write accepted when high with reg_we_o
//   err_o, err_code_o      : one-cycle error pulse and its cause
//   ok_cnt_o               : completed writes (wraps)
//   err_cnt_o              : error pulses (saturates at 255)
// ----------------------------------------------------------------------------
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 270000,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        reg_we_o,
   output logic [3:0]  reg_addr_o,
   output logic [15:0] reg_wdata_o,
   input  logic        reg_ready_i,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [7:0]  ok_cnt_o,
   output logic [7:0]  err_cnt_o
);

   state_e      r_state;
   logic [7:0]  r_cmd;
   logic [7:0]  r_dhi;
   logic [7:0]  r_dlo;
   logic        r_we;
   logic [3:0]  r_addr;
   logic [15:0] r_wdata;
   logic        r_err;
   logic [1:0]  r_err_code;
   logic [7:0]  r_ok_cnt;
   logic [7:0]  r_err_cnt;

   logic        w_timed;
   logic        w_tmo_clear;
   logic        w_expired;

   // Every entry into a timed state is caused by a byte, so clearing on each
   // accepted byte also restarts the count on state entry.
   assign w_timed     = (r_state == ST_CMD) || (r_state == ST_DHI) ||
                        (r_state == ST_DLO) || (r_state == ST_CHK);
   assign w_tmo_clear = rx_valid_i || !w_timed;

   byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_byte_timeout (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (w_tmo_clear),
      .enable (w_timed),
      .expired(w_expired)
   );

   // Frame FSM with payload latches, registered outputs and counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_cmd      <= 8'h00;
         r_dhi      <= 8'h00;
         r_dlo      <= 8'h00;
         r_we       <= 1'b0;
         r_addr     <= 4'h0;
         r_wdata    <= 16'h0000;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
         r_ok_cnt   <= 8'h00;
         r_err_cnt  <= 8'h00;
      end else begin
         r_err <= 1'b0;
         // A byte arriving on the expiry cycle takes priority over the timeout.
         if (w_expired && !rx_valid_i) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_err_cnt  <= sat_inc8(r_err_cnt);
            r_state    <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                     r_state <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (rx_valid_i) begin
                     r_cmd <= rx_data_i;
                     if (rx_data_i[CMD_WRITE_BIT]) begin
                        r_state <= ST_DHI;
                     end else begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_BADCMD;
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_state    <= ST_IDLE;
                     end
                  end
               end
               ST_DHI: begin
                  if (rx_valid_i) begin
                     r_dhi   <= rx_data_i;
                     r_state <= ST_DLO;
                  end
               end
               ST_DLO: begin
                  if (rx_valid_i) begin
                     r_dlo   <= rx_data_i;
                     r_state <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (rx_valid_i) begin
                     if (frame_chk(r_cmd, r_dhi, r_dlo) == rx_data_i) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        r_wdata <= {r_dhi, r_dlo};
                        r_state <= ST_WRITE;
                     end else begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_CHK;
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_state    <= ST_IDLE;
                     end
                  end
               end
               ST_WRITE: begin
                  // Bytes during a pending write are dropped; the write itself
                  // is untouched.
                  if (rx_valid_i) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_OVERRUN;
                     r_err_cnt  <= sat_inc8(r_err_cnt);
                  end
                  if (reg_ready_i) begin
                     r_we     <= 1'b0;
                     r_ok_cnt <= r_ok_cnt + 8'd1;
                     r_state  <= ST_IDLE;
                  end
               end
               default: begin
                  r_we    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign reg_we_o    = r_we;
   assign reg_addr_o  = r_addr;
   assign reg_wdata_o = r_wdata;
   assign err_o       = r_err;
   assign err_code_o  = r_err_code;
   assign ok_cnt_o    = r_ok_cnt;
   assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Self-checking bench: a table of whole frames with their expected outcome,
// hand-written sequences for backpressure, timeout, saturation and reset,
// then randomized frames compared against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;
   import uart_cmd_ctrl_pkg::*;

   localparam int TMO = 100;

   logic        clk_i       = 1'b0;
   logic        rst_ni      = 1'b0;
   logic [7:0]  rx_data_i   = 8'h00;
   logic        rx_valid_i  = 1'b0;
   logic        reg_ready_i = 1'b0;
   logic        reg_we_o;
   logic [3:0]  reg_addr_o;
   logic [15:0] reg_wdata_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic [7:0]  ok_cnt_o;
   logic [7:0]  err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic [7:0]  exp_ok  = 8'h00;
   int          exp_err = 0;
   logic [19:0] exp_wr[$];
   logic [1:0]  exp_ec[$];
   logic [19:0] got_wr[$];
   logic [1:0]  got_ec[$];
   bit          mon_en   = 1'b0;
   int          wr_count = 0;

   typedef struct {
      int              nb;
      logic [4:0][7:0] b;
      bit              wr;
      logic [3:0]      addr;
      logic [15:0]     data;
      bit              er;
      logic [1:0]      code;
   } vec_t;
   vec_t vt[8];

   uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .reg_we_o   (reg_we_o),
      .reg_addr_o (reg_addr_o),
      .reg_wdata_o(reg_wdata_o),
      .reg_ready_i(reg_ready_i),
      .err_o      (err_o),
      .err_code_o (err_code_o),
      .ok_cnt_o   (ok_cnt_o),
      .err_cnt_o  (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Transaction monitor, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (reg_we_o && reg_ready_i) begin
         wr_count++;
         if (mon_en) got_wr.push_back({reg_addr_o, reg_wdata_o});
      end
      if (err_o && mon_en) got_ec.push_back(err_code_o);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      step();
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
      send_byte(8'hA5); send_byte(c); send_byte(h); send_byte(l); send_byte(k);
   endtask

   task automatic do_reset();
      rx_valid_i  = 1'b0;
      reg_ready_i = 1'b0;
      rst_ni      = 1'b0;
      step(); step();
      rst_ni = 1'b1;
      step();
      exp_ok  = 8'h00;
      exp_err = 0;
   endtask

   task automatic model_err(input logic [1:0] code);
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
      exp_ec.push_back(code);
   endtask

   task automatic model_write(input logic [3:0] a, input logic [15:0] d);
      exp_ok = exp_ok + 8'd1;
      exp_wr.push_back({a, d});
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) step();
   endtask

   // Random frame generator; expectations come from the frame rules directly.
   task automatic random_frame();
      int         kind;
      int         d;
      int         ovpos;
      logic [7:0] c, h, l, k, b;
      kind = $urandom_range(0, 9);
      c = 8'($urandom_range(0, 255));
      h = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 255));
      if (kind <= 6) begin
         c = c | 8'h80;
         k = c ^ h ^ l;
         if (kind >= 5) k = k ^ 8'($urandom_range(1, 255));
         send_byte(8'hA5); gap(); send_byte(c); gap(); send_byte(h); gap();
         send_byte(l); gap(); send_byte(k);
         if (kind <= 4) begin
            d     = $urandom_range(0, 4);
            ovpos = ($urandom_range(0, 1) == 1 && d > 0) ? $urandom_range(0, d - 1) : -1;
            for (int s = 0; s < d; s++) begin
               if (s == ovpos) begin
                  rx_valid_i = 1'b1;
                  rx_data_i  = 8'($urandom_range(0, 255));
                  model_err(ERR_OVERRUN);
               end
               step();
               rx_valid_i = 1'b0;
            end
            reg_ready_i = 1'b1;
            step();
            reg_ready_i = 1'b0;
            model_write(c[3:0], {h, l});
         end else begin
            model_err(ERR_CHK);
         end
      end else if (kind == 7) begin
         send_byte(8'hA5); gap(); send_byte(c & 8'h7F);
         model_err(ERR_BADCMD);
      end else begin
         for (int n = 0; n < $urandom_range(1, 3); n++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
         end
      end
      gap();
   endtask

   initial begin
      int wr_before;

      vt[0] = '{5, {8'hA5, 8'h82, 8'h12, 8'h34, 8'hA4}, 1'b1, 4'h2, 16'h1234, 1'b0, 2'd0};
      vt[1] = '{5, {8'hA5, 8'h82, 8'h12, 8'h34, 8'hA5}, 1'b0, 4'h0, 16'h0000, 1'b1, 2'd0};
      vt[2] = '{5, {8'hA5, 8'h82, 8'h12, 8'h34, 8'hA4}, 1'b1, 4'h2, 16'h1234, 1'b0, 2'd0};
      vt[3] = '{5, {8'hA5, 8'h8F, 8'hFF, 8'h00, 8'h70}, 1'b1, 4'hF, 16'hFF00, 1'b0, 2'd0};
      vt[4] = '{5, {8'hA5, 8'hF3, 8'hA5, 8'hA5, 8'hF3}, 1'b1, 4'h3, 16'hA5A5, 1'b0, 2'd0};
      vt[5] = '{2, {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00}, 1'b0, 4'h0, 16'h0000, 1'b1, 2'd2};
      vt[6] = '{5, {8'hA5, 8'h81, 8'h00, 8'h01, 8'h80}, 1'b1, 4'h1, 16'h0001, 1'b0, 2'd0};
      vt[7] = '{5, {8'hA5, 8'hC7, 8'h00, 8'h01, 8'hC7}, 1'b0, 4'h0, 16'h0000, 1'b1, 2'd0};

      // Reset values
      do_reset();
      check("rst_we", reg_we_o, 1'b0);
      check("rst_addr", reg_addr_o, 4'h0);
      check("rst_wdata", reg_wdata_o, 16'h0000);
      check("rst_err", err_o, 1'b0);
      check("rst_code", err_code_o, 2'd0);
      check("rst_ok", ok_cnt_o, 8'h00);
      check("rst_errcnt", err_cnt_o, 8'h00);

      // Table of frames, ready held high
      reg_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < vt[i].nb; j++) send_byte(vt[i].b[4-j]);
         check("tbl_we", reg_we_o, vt[i].wr);
         check("tbl_err", err_o, vt[i].er);
         if (vt[i].wr) begin
            check("tbl_addr", reg_addr_o, vt[i].addr);
            check("tbl_data", reg_wdata_o, vt[i].data);
            exp_ok = exp_ok + 8'd1;
         end
         if (vt[i].er) begin
            check("tbl_code", err_code_o, vt[i].code);
            exp_err = exp_err + 1;
         end
         step();
         check("tbl_we_done", reg_we_o, 1'b0);
         check("tbl_err_done", err_o, 1'b0);
         check("tbl_ok_cnt", ok_cnt_o, exp_ok);
         check("tbl_err_cnt", err_cnt_o, exp_err);
      end
      reg_ready_i = 1'b0;

      // Backpressure: ready low 5 cycles, overrun byte in the middle
      do_reset();
      wr_before = wr_count;
      send_frame(8'h82, 8'h12, 8'h34, 8'hA4);
      for (int i = 0; i < 6; i++) begin
         check("bp_we", reg_we_o, 1'b1);
         check("bp_addr", reg_addr_o, 4'h2);
         check("bp_data", reg_wdata_o, 16'h1234);
         if (i == 2) begin
            rx_valid_i = 1'b1;
            rx_data_i  = 8'h5A;
         end
         if (i == 5) reg_ready_i = 1'b1;
         step();
         rx_valid_i = 1'b0;
         if (i == 2) begin
            check("bp_ovr_err", err_o, 1'b1);
            check("bp_ovr_code", err_code_o, ERR_OVERRUN);
            check("bp_ovr_cnt", err_cnt_o, 8'd1);
         end
      end
      reg_ready_i = 1'b0;
      check("bp_we_done", reg_we_o, 1'b0);
      check("bp_ok_cnt", ok_cnt_o, 8'd1);
      check("bp_one_xfer", wr_count - wr_before, 1);

      // Noise then bad command
      do_reset();
      send_byte(8'h00); check("noise0_err", err_o, 1'b0);
      send_byte(8'h55); check("noise1_err", err_o, 1'b0);
      send_byte(8'hA5); check("sync_err", err_o, 1'b0);
      send_byte(8'h02);
      check("badcmd_err", err_o, 1'b1);
      check("badcmd_code", err_code_o, ERR_BADCMD);
      step();
      check("badcmd_pulse", err_o, 1'b0);
      check("badcmd_cnt", err_cnt_o, 8'd1);

      // Timeout after 100 idle cycles
      do_reset();
      send_byte(8'hA5); send_byte(8'h82);
      repeat (TMO - 1) step();
      check("tmo_early", err_o, 1'b0);
      step();
      check("tmo_err", err_o, 1'b1);
      check("tmo_code", err_code_o, ERR_TIMEOUT);
      wr_before = wr_count;
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hA4);
      step();
      check("tmo_idle_we", reg_we_o, 1'b0);
      check("tmo_idle_xfer", wr_count - wr_before, 0);
      check("tmo_errcnt", err_cnt_o, 8'd1);

      // Byte arriving on the expiry cycle wins
      do_reset();
      send_byte(8'hA5); send_byte(8'h82);
      repeat (TMO - 1) step();
      send_byte(8'h12);
      check("tmo_race_err", err_o, 1'b0);
      send_byte(8'h34); send_byte(8'hA4);
      check("tmo_race_we", reg_we_o, 1'b1);
      check("tmo_race_data", reg_wdata_o, 16'h1234);
      check("tmo_race_errcnt", err_cnt_o, 8'd0);
      reg_ready_i = 1'b1; step(); reg_ready_i = 1'b0;
      check("tmo_race_ok", ok_cnt_o, 8'd1);

      // Reset after the DHI byte aborts the frame
      do_reset();
      reg_ready_i = 1'b1;
      send_frame(8'h82, 8'h12, 8'h34, 8'hA4);
      step();
      reg_ready_i = 1'b0;
      send_byte(8'h02);
      send_byte(8'hA5); send_byte(8'h82); send_byte(8'h12);
      rst_ni = 1'b0;
      #1;
      check("mrst_we", reg_we_o, 1'b0);
      check("mrst_addr", reg_addr_o, 4'h0);
      check("mrst_wdata", reg_wdata_o, 16'h0000);
      check("mrst_err", err_o, 1'b0);
      check("mrst_code", err_code_o, 2'd0);
      check("mrst_ok", ok_cnt_o, 8'h00);
      check("mrst_errcnt", err_cnt_o, 8'h00);
      step();
      rst_ni = 1'b1;
      wr_before = wr_count;
      reg_ready_i = 1'b1;
      send_byte(8'h34); send_byte(8'hA4);
      step();
      reg_ready_i = 1'b0;
      check("mrst_no_xfer", wr_count - wr_before, 0);
      check("mrst_no_err", err_cnt_o, 8'h00);

      // ok counter wraps after 256 writes
      do_reset();
      reg_ready_i = 1'b1;
      for (int i = 0; i < 256; i++) begin
         send_frame(8'h82, 8'h12, 8'h34, 8'hA4);
         step();
         if (i == 254) check("ok_255", ok_cnt_o, 8'd255);
      end
      reg_ready_i = 1'b0;
      check("ok_wrap", ok_cnt_o, 8'd0);

      // err counter saturates
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send_byte(8'hA5); send_byte(8'h02);
         if (i == 253) check("err_254", err_cnt_o, 8'd254);
      end
      step();
      check("err_sat", err_cnt_o, 8'd255);

      // Randomized frames against the transaction model
      do_reset();
      exp_wr.delete(); exp_ec.delete(); got_wr.delete(); got_ec.delete();
      mon_en = 1'b1;
      for (int f = 0; f < 80; f++) random_frame();
      repeat (3) step();
      mon_en = 1'b0;
      check("rnd_nwr", got_wr.size(), exp_wr.size());
      check("rnd_nerr", got_ec.size(), exp_ec.size());
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
         check("rnd_wr", got_wr[i], exp_wr[i]);
      for (int i = 0; i < exp_ec.size() && i < got_ec.size(); i++)
         check("rnd_code", got_ec[i], exp_ec[i]);
      check("rnd_ok_cnt", ok_cnt_o, exp_ok);
      check("rnd_err_cnt", err_cnt_o, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
